// File: rtl/token_frame_sender.sv
// Transmit side of the Fs/X0/One/Zero/Fd/Fe token link: one command per frame, 4-phase handshake per token.
// Optional macro ACK_SYNC_EN adds a 2-flop synchroniser on every ack input.
module token_frame_sender #(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned TO_W        = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_channel,
  input  logic cmd_dir,
  output logic Fs,
  output logic X0,
  output logic One,
  output logic Zero,
  output logic Fd,
  output logic Fe,
  input  logic Fs_ack,
  input  logic X0_ack,
  input  logic one_ack,
  input  logic zero_ack,
  input  logic Fd_ack,
  input  logic Fe_ack,
  output logic busy,
  output logic frame_done,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FS   = 3'd1,
    S_SRC  = 3'd2,
    S_X0   = 3'd3,
    S_DAT  = 3'd4,
    S_FD   = 3'd5,
    S_FE   = 3'd6
  } state_e;

  // Line vector bit order: {Fs, X0, One, Zero, Fd, Fe}
  localparam logic [5:0] TK_FS   = 6'b100000;
  localparam logic [5:0] TK_X0   = 6'b010000;
  localparam logic [5:0] TK_ONE  = 6'b001000;
  localparam logic [5:0] TK_ZERO = 6'b000100;
  localparam logic [5:0] TK_FD   = 6'b000010;
  localparam logic [5:0] TK_FE   = 6'b000001;

  localparam bit             TO_EN   = (ACK_TIMEOUT != 32'd0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT == 32'd0) ? 32'd0 : ACK_TIMEOUT - 32'd1);

  function automatic logic [5:0] token_of(input state_e st, input logic ch, input logic dr);
    case (st)
      S_FS:    token_of = TK_FS;
      S_SRC:   token_of = ch ? TK_ONE : TK_ZERO;
      S_X0:    token_of = TK_X0;
      S_DAT:   token_of = dr ? TK_ONE : TK_ZERO;
      S_FD:    token_of = TK_FD;
      S_FE:    token_of = TK_FE;
      default: token_of = 6'b000000;
    endcase
  endfunction

  function automatic state_e next_token(input state_e st);
    case (st)
      S_FS:    next_token = S_SRC;
      S_SRC:   next_token = S_X0;
      S_X0:    next_token = S_DAT;
      S_DAT:   next_token = S_FD;
      S_FD:    next_token = S_FE;
      default: next_token = S_IDLE;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic            ph_q, ph_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            chan_q, chan_d;
  logic            dir_q, dir_d;
  logic [5:0]      tok_q, tok_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;

  logic [5:0] ack_raw;
  logic [5:0] ack_use;
  logic       match_ack;
  logic       timeout_hit;

  assign ack_raw = {Fs_ack, X0_ack, one_ack, zero_ack, Fd_ack, Fe_ack};

`ifdef ACK_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  // Two-stage synchroniser for the asynchronous decoder acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 6'b000000;
      sync2_q <= 6'b000000;
    end else begin
      sync1_q <= ack_raw;
      sync2_q <= sync1_q;
    end
  end

  assign ack_use = sync2_q;
`else
  assign ack_use = ack_raw;
`endif

  // Only the ack of the token owned by the current state counts; the rest are ignored
  assign match_ack   = |(token_of(state_q, chan_q, dir_q) & ack_use);
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state: DRIVE waits for ack high, RELEASE waits for ack low, any phase may time out
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    dir_d   = dir_q;
    tok_d   = tok_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          chan_d  = cmd_channel;
          dir_d   = cmd_dir;
          state_d = S_FS;
          ph_d    = 1'b0;
          cnt_d   = {TO_W{1'b0}};
          tok_d   = TK_FS;
        end else begin
          tok_d = 6'b000000;
        end
      end
      S_FS, S_SRC, S_X0, S_DAT, S_FD, S_FE: begin
        if (!ph_q && match_ack) begin
          ph_d  = 1'b1;
          tok_d = 6'b000000;
          cnt_d = {TO_W{1'b0}};
        end else if (ph_q && !match_ack) begin
          ph_d  = 1'b0;
          cnt_d = {TO_W{1'b0}};
          if (state_q == S_FE) begin
            state_d = S_IDLE;
            tok_d   = 6'b000000;
            done_d  = 1'b1;
          end else begin
            state_d = next_token(state_q);
            tok_d   = token_of(next_token(state_q), chan_q, dir_q);
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          ph_d    = 1'b0;
          cnt_d   = {TO_W{1'b0}};
          tok_d   = 6'b000000;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(32'd1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = 1'b0;
        cnt_d   = {TO_W{1'b0}};
        tok_d   = 6'b000000;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= {TO_W{1'b0}};
      chan_q  <= 1'b0;
      dir_q   <= 1'b0;
      tok_q   <= 6'b000000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      dir_q   <= dir_d;
      tok_q   <= tok_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign {Fs, X0, One, Zero, Fd, Fe} = tok_q;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_token_frame_sender.sv
// Self-checking bench for token_frame_sender: delayed-echo ack responder plus a frame-level timing model.
module tb_token_frame_sender;

  localparam int ACK_TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, cmd_channel, cmd_dir;
  logic Fs, X0, One, Zero, Fd, Fe;
  logic Fs_ack, X0_ack, one_ack, zero_ack, Fd_ack, Fe_ack;
  logic busy, frame_done, timeout_err;

  always #5 clk = ~clk;

  token_frame_sender #(.ACK_TIMEOUT(ACK_TO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_dir(cmd_dir),
    .Fs(Fs), .X0(X0), .One(One), .Zero(Zero), .Fd(Fd), .Fe(Fe),
    .Fs_ack(Fs_ack), .X0_ack(X0_ack), .one_ack(one_ack), .zero_ack(zero_ack),
    .Fd_ack(Fd_ack), .Fe_ack(Fe_ack),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  // Responder: each ack echoes its line after resp_delay cycles; block_m suppresses, force_m injects
  logic [5:0] tok_s;
  logic [5:0] hist0, hist1, hist2;
  logic [5:0] ack_dly, ack_v;
  int         resp_delay;
  logic [5:0] block_m, force_m;

  assign tok_s = {Fs, X0, One, Zero, Fd, Fe};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0 <= 6'd0; hist1 <= 6'd0; hist2 <= 6'd0;
    end else begin
      hist0 <= tok_s; hist1 <= hist0; hist2 <= hist1;
    end
  end

  always_comb begin
    case (resp_delay)
      0:       ack_dly = tok_s;
      1:       ack_dly = hist0;
      2:       ack_dly = hist1;
      default: ack_dly = hist2;
    endcase
    ack_v = (ack_dly & ~block_m) | force_m;
  end

  assign {Fs_ack, X0_ack, one_ack, zero_ack, Fd_ack, Fe_ack} = ack_v;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] tq[$];
  bit         dq[$], eq[$], rq[$], bq[$];
  int         seg_tok[$], seg_len[$], seg_start[$];
  int         exp_q[$];
  int         multi_hot;

  // Expected token order: Fs, source bit, X0, data bit, Fd, Fe (bit index 5..0 = Fs,X0,One,Zero,Fd,Fe)
  function automatic void push_frame(input logic ch, input logic dr);
    exp_q.push_back(5);
    exp_q.push_back(ch ? 3 : 2);
    exp_q.push_back(4);
    exp_q.push_back(dr ? 3 : 2);
    exp_q.push_back(1);
    exp_q.push_back(0);
  endfunction

  function automatic int tok_index(input logic [5:0] v);
    for (int k = 5; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  function automatic void analyze();
    seg_tok.delete(); seg_len.delete(); seg_start.delete();
    multi_hot = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if ($countones(tq[i]) > 1) multi_hot++;
      if (tq[i] != 6'd0) begin
        if (i == 0 || tq[i] != tq[i-1]) begin
          seg_tok.push_back(tok_index(tq[i]));
          seg_len.push_back(1);
          seg_start.push_back(i);
        end else begin
          seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
        end
      end
    end
  endfunction

  function automatic int nth_done(input int n);
    int c = 0;
    for (int i = 0; i < dq.size(); i++) begin
      if (dq[i]) begin
        c++;
        if (c == n) return i;
      end
    end
    return -1;
  endfunction

  task automatic start_cmd(input logic ch, input logic dr);
    @(negedge clk);
    cmd_channel = ch;
    cmd_dir     = dr;
    cmd_valid   = 1'b1;
  endtask

  // Record one sample per cycle from the first negedge after acceptance
  task automatic capture(input int budget, input int want_done, input bit hold, input logic ch2, input logic dr2);
    int dones = 0;
    tq.delete(); dq.delete(); eq.delete(); rq.delete(); bq.delete();
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      tq.push_back(tok_s); dq.push_back(frame_done); eq.push_back(timeout_err);
      rq.push_back(cmd_ready); bq.push_back(busy);
      if (i == 0) begin
        if (hold) begin
          cmd_channel = ch2;
          cmd_dir     = dr2;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (frame_done) dones++;
      if (hold && dones == 1 && Fs) cmd_valid = 1'b0;
      if (dones >= want_done || timeout_err) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (tok_s !== 6'd0 || busy !== 1'b0 || frame_done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: lines=%b busy=%b done=%b terr=%b, want all 0", tok_s, busy, frame_done, timeout_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || tok_s !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b lines=%b, want 1 0 000000", cmd_ready, busy, tok_s);
    end
  endtask

  // One clean frame: order, per-token hold, frame_done time, one-hot, ready/busy during and after
  task automatic test_clean_frame(input logic ch, input logic dr, input int d);
    int h, bad_r, bad_b;
    h = d + 1;
    resp_delay = d;
    exp_q.delete();
    push_frame(ch, dr);
    start_cmd(ch, dr);
    capture(200, 1, 1'b0, 1'b0, 1'b0);
    analyze();
    n_checks++;
    if (seg_tok.size() !== 6) begin
      n_fail++;
      $display("FAIL frame_tokens ch=%0d dir=%0d d=%0d: got %0d tokens, want 6", ch, dr, d, seg_tok.size());
    end
    for (int k = 0; k < 6 && k < seg_tok.size(); k++) begin
      n_checks++;
      if (seg_tok[k] !== exp_q[k] || seg_len[k] !== h) begin
        n_fail++;
        $display("FAIL frame_token%0d ch=%0d dir=%0d: got line %0d for %0d cyc, want line %0d for %0d cyc",
                 k, ch, dr, seg_tok[k], seg_len[k], exp_q[k], h);
      end
    end
    n_checks++;
    if (nth_done(1) !== 12 * h) begin
      n_fail++;
      $display("FAIL frame_done_time d=%0d: got idx %0d, want %0d", d, nth_done(1), 12 * h);
    end
    n_checks++;
    if (multi_hot !== 0) begin
      n_fail++;
      $display("FAIL one_hot: got %0d multi-hot cycles, want 0", multi_hot);
    end
    bad_r = 0; bad_b = 0;
    for (int i = 0; i < 12 * h && i < rq.size(); i++) begin
      if (rq[i] !== 1'b0) bad_r++;
      if (bq[i] !== 1'b1) bad_b++;
    end
    n_checks++;
    if (bad_r !== 0 || bad_b !== 0) begin
      n_fail++;
      $display("FAIL ready_busy_in_frame: got %0d ready-high, %0d busy-low cycles, want 0 0", bad_r, bad_b);
    end
    n_checks++;
    if (tq.size() <= 12 * h || rq[12 * h] !== 1'b1 || bq[12 * h] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got %0d samples, want ready=1 busy=0 at idx %0d", tq.size(), 12 * h);
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got frame_done=%b one cycle later, want 0", frame_done);
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 8; n++)
      test_clean_frame(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
  endtask

  task automatic test_timeout();
    logic ch, dr;
    int d, h;
    ch = 1'($urandom_range(1, 0));
    dr = 1'($urandom_range(1, 0));
    d  = int'($urandom_range(2, 0));
    h  = d + 1;
    resp_delay = d;
    block_m = 6'b010000;
    start_cmd(ch, dr);
    capture(200, 1, 1'b0, 1'b0, 1'b0);
    analyze();
    n_checks++;
    if (seg_tok.size() !== 3 || seg_tok[2] !== 4 || seg_len[2] !== ACK_TO || seg_start[2] !== 4 * h) begin
      n_fail++;
      $display("FAIL timeout_x0_hold: got %0d tokens, last line %0d len %0d at %0d, want 3 tokens, line 4 len %0d at %0d",
               seg_tok.size(), seg_tok[seg_tok.size()-1], seg_len[seg_len.size()-1],
               seg_start[seg_start.size()-1], ACK_TO, 4 * h);
    end
    n_checks++;
    if (eq.size() !== 4 * h + ACK_TO + 1 || eq[eq.size()-1] !== 1'b1 || tq[tq.size()-1] !== 6'd0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got terr at idx %0d lines=%b, want idx %0d lines 000000",
               eq.size() - 1, tq[tq.size()-1], 4 * h + ACK_TO);
    end
    n_checks++;
    if (nth_done(1) !== -1 || rq[rq.size()-1] !== 1'b1 || bq[bq.size()-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got done idx %0d ready=%b busy=%b, want -1 1 0",
               nth_done(1), rq[rq.size()-1], bq[bq.size()-1]);
    end
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: got %b one cycle later, want 0", timeout_err);
    end
    block_m = 6'b000000;
    repeat (4) @(negedge clk);
    test_clean_frame(~ch, dr, 0);
  endtask

  task automatic test_spurious();
    force_m = 6'b001000;
    test_clean_frame(1'b0, 1'b0, 3);
    force_m = 6'b000000;
  endtask

  task automatic test_reset_mid();
    logic ch, dr;
    int bit_i, late_done;
    ch = 1'($urandom_range(1, 0));
    dr = 1'($urandom_range(1, 0));
    bit_i = dr ? 3 : 2;
    resp_delay = 1;
    start_cmd(ch, dr);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
    end
    n_checks++;
    if (tok_s[bit_i] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dat_line: got lines=%b, want data line %0d high", tok_s, bit_i);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tok_s !== 6'd0 || busy !== 1'b0 || frame_done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: lines=%b busy=%b done=%b terr=%b, want all 0", tok_s, busy, frame_done, timeout_err);
    end
    late_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || timeout_err !== 1'b0) late_done++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (frame_done !== 1'b0) late_done++;
    n_checks++;
    if (late_done !== 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_pulse: got %0d pulse cycles ready=%b, want 0 1", late_done, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic ca, da, cb, db;
    int bad_r, k;
    ca = 1'($urandom_range(1, 0)); da = 1'($urandom_range(1, 0));
    cb = 1'($urandom_range(1, 0)); db = 1'($urandom_range(1, 0));
    resp_delay = 0;
    exp_q.delete();
    push_frame(ca, da);
    push_frame(cb, db);
    start_cmd(ca, da);
    capture(200, 2, 1'b1, cb, db);
    analyze();
    n_checks++;
    if (nth_done(1) !== 12 || nth_done(2) !== 25) begin
      n_fail++;
      $display("FAIL b2b_done_times: got %0d and %0d, want 12 and 25", nth_done(1), nth_done(2));
    end
    bad_r = 0;
    for (int i = 0; i < 12 && i < rq.size(); i++) if (rq[i] !== 1'b0) bad_r++;
    n_checks++;
    if (bad_r !== 0 || rq.size() < 14 || rq[12] !== 1'b1 || tq[13] !== 6'b100000 || bq[13] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d ready-high in frame, %0d samples, want 0 and second Fs at idx 13", bad_r, rq.size());
    end
    k = 0;
    for (int i = 0; i < seg_tok.size() && i < 12; i++) if (seg_tok[i] !== exp_q[i]) k++;
    n_checks++;
    if (seg_tok.size() !== 12 || k !== 0) begin
      n_fail++;
      $display("FAIL b2b_order: got %0d tokens with %0d wrong, want 12 with 0 wrong", seg_tok.size(), k);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_channel = 1'b0; cmd_dir = 1'b0;
    resp_delay = 0; block_m = 6'b000000; force_m = 6'b000000;
    test_reset();
    test_clean_frame(1'b1, 1'b1, 0);
    test_clean_frame(1'b0, 1'b0, 3);
    test_random_frames();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
